// File: rtl/mips_pkg.sv
// Shared MIPS definitions: register-file geometry, named register indices and the basic
// word/index types used by the core and the register file.
package mips_pkg;

   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [REG_W-1:0]      word_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
   localparam reg_idx_t REG_SP   = 5'd29;
   localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file.sv
// MIPS general-purpose register file: 2 combinational read ports, 1 synchronous write port, r0 = 0.
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module reg_file
   import mips_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] wr_num,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] rd0_num,
   output logic [DATA_W-1:0] rd0_data,
   input  logic [ADDR_W-1:0] rd1_num,
   output logic [DATA_W-1:0] rd1_data
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   // r0 has no storage; the array starts at index 1.
   logic [DATA_W-1:0] regs_reg [1:DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wr_en && (wr_num != ZERO_IDX)) begin
         regs_reg[wr_num] <= wr_data;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] num);
      if (num == ZERO_IDX) begin
         return '0;
      end
      return regs_reg[num];
   endfunction

`ifdef REGFILE_BYPASS_EN
   // Forward the pending write; suppressed while reset is asserted so outputs stay 0.
   logic bypass_ok;
   assign bypass_ok = reset && wr_en && (wr_num != ZERO_IDX);
`endif

   always_comb begin
      rd0_data = read_port(rd0_num);
`ifdef REGFILE_BYPASS_EN
      if (bypass_ok && (wr_num == rd0_num)) begin
         rd0_data = wr_data;
      end
`endif
   end

   always_comb begin
      rd1_data = read_port(rd1_num);
`ifdef REGFILE_BYPASS_EN
      if (bypass_ok && (wr_num == rd1_num)) begin
         rd1_data = wr_data;
      end
`endif
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file;
   import mips_pkg::*;

   logic     clk = 1'b0;
   logic     reset = 1'b0;
   reg_idx_t wr_num = '0;
   word_t    wr_data = '0;
   logic     wr_en = 1'b0;
   reg_idx_t rd0_num = '0;
   word_t    rd0_data;
   reg_idx_t rd1_num = '0;
   word_t    rd1_data;

   int checks = 0;
   int failures = 0;

   reg_file dut (
      .clk      (clk),
      .reset    (reset),
      .wr_num   (wr_num),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .rd0_num  (rd0_num),
      .rd0_data (rd0_data),
      .rd1_num  (rd1_num),
      .rd1_data (rd1_data)
   );

   always #5 clk = ~clk;

   // Present a write at the falling edge, let one rising edge take it, then drop wr_en.
   task automatic do_write(input reg_idx_t num, input word_t data);
      @(negedge clk);
      wr_num  = num;
      wr_data = data;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      $display("WRITE r%0d <= %08h", num, data);
   endtask

   task automatic test_reset();
      word_t exp;
      rd0_num = 5'd9;
      rd1_num = REG_RA;
      #1;
      checks++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_initial: rd0=%08h rd1=%08h required 00000000", rd0_data, rd1_data);
      end
      @(negedge clk);
      reset = 1'b1;
      do_write(5'd5, 32'hDEADBEEF);
      rd0_num = 5'd5;
      #1;
      exp = 32'hDEADBEEF;
      checks++;
      if (rd0_data !== exp) begin
         failures++;
         $display("FAIL reset_prewrite: rd0=%08h required %08h", rd0_data, exp);
      end
      // Mid-cycle assertion, no clock edge between assertion and check.
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (rd0_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_async: rd0=%08h required 00000000", rd0_data);
      end
      $display("RESET async clear r5 -> %08h", rd0_data);
      // Writes during reset are ignored.
      @(negedge clk);
      wr_num = 5'd6; wr_data = 32'hCAFEF00D; wr_en = 1'b1;
      rd1_num = 5'd6;
      #1;
      checks++;
      if (rd1_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_no_bypass: rd1=%08h required 00000000", rd1_data);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (rd1_data !== 32'h0 || rd0_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_write_ignored: r6=%08h r5=%08h required 00000000", rd1_data, rd0_data);
      end
      // First edge after release accepts a write.
      wr_num = 5'd6; wr_data = 32'h00000066; wr_en = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      checks++;
      if (rd1_data !== 32'h00000066) begin
         failures++;
         $display("FAIL reset_release_write: r6=%08h required 00000066", rd1_data);
      end
   endtask

   task automatic test_write_read();
      do_write(REG_RA, 32'h00000055);
      do_write(REG_SP, 32'h80120000);
      do_write(REG_RA, 32'h00000000);
      rd0_num = REG_SP;
      rd1_num = REG_RA;
      #1;
      checks++;
      if (rd0_data !== 32'h80120000) begin
         failures++;
         $display("FAIL write_read_sp: rd0=%08h required 80120000", rd0_data);
      end
      checks++;
      if (rd1_data !== 32'h00000000) begin
         failures++;
         $display("FAIL write_read_ra: rd1=%08h required 00000000", rd1_data);
      end
      $display("READ r29=%08h r31=%08h", rd0_data, rd1_data);
   endtask

   task automatic test_r0();
      @(negedge clk);
      wr_num = REG_ZERO; wr_data = 32'hFFFFFFFF; wr_en = 1'b1;
      rd0_num = REG_ZERO; rd1_num = REG_ZERO;
      #1;
      checks++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0) begin
         failures++;
         $display("FAIL r0_no_bypass: rd0=%08h rd1=%08h required 00000000", rd0_data, rd1_data);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      checks++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0) begin
         failures++;
         $display("FAIL r0_write_discarded: rd0=%08h rd1=%08h required 00000000", rd0_data, rd1_data);
      end
      $display("R0 after write FFFFFFFF -> %08h/%08h", rd0_data, rd1_data);
   endtask

   task automatic test_wr_en_low();
      do_write(5'd7, 32'h00000077);
      @(negedge clk);
      wr_num = 5'd7; wr_data = 32'h00001234; wr_en = 1'b0;
      rd0_num = 5'd7;
      @(posedge clk);
      #1;
      checks++;
      if (rd0_data !== 32'h00000077) begin
         failures++;
         $display("FAIL wr_en_low: r7=%08h required 00000077", rd0_data);
      end
      $display("WR_EN_LOW r7=%08h", rd0_data);
   endtask

   task automatic test_same_cycle();
      word_t exp_before;
`ifdef REGFILE_BYPASS_EN
      exp_before = 32'h00000022;
`else
      exp_before = 32'h00000011;
`endif
      do_write(5'd3, 32'h00000011);
      @(negedge clk);
      wr_num = 5'd3; wr_data = 32'h00000022; wr_en = 1'b1;
      rd1_num = 5'd3;
      rd0_num = 5'd7;
      #1;
      checks++;
      if (rd1_data !== exp_before) begin
         failures++;
         $display("FAIL same_cycle_before: rd1=%08h required %08h", rd1_data, exp_before);
      end
      checks++;
      if (rd0_data !== 32'h00000077) begin
         failures++;
         $display("FAIL same_cycle_other_port: rd0=%08h required 00000077", rd0_data);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      checks++;
      if (rd1_data !== 32'h00000022) begin
         failures++;
         $display("FAIL same_cycle_after: rd1=%08h required 00000022", rd1_data);
      end
      $display("SAME_CYCLE r3 before=%08h after=%08h", exp_before, rd1_data);
   endtask

   task automatic test_sweep();
      word_t exp;
      int bad;
      for (int i = 1; i < 32; i++) begin
         do_write(reg_idx_t'(i), word_t'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         rd0_num = reg_idx_t'(i);
         rd1_num = reg_idx_t'(31 - i);
         #1;
         exp = word_t'(i) * 32'h01010101;
         checks++;
         if (rd0_data !== exp) begin
            failures++;
            $display("FAIL sweep_rd0 r%0d: got %08h required %08h", i, rd0_data, exp);
         end
         exp = word_t'(31 - i) * 32'h01010101;
         checks++;
         if (rd1_data !== exp) begin
            failures++;
            $display("FAIL sweep_rd1 r%0d: got %08h required %08h", 31 - i, rd1_data, exp);
         end
      end
      // Same index on both ports.
      bad = 0;
      rd0_num = 5'd17;
      rd1_num = 5'd17;
      #1;
      checks++;
      if (rd0_data !== 32'h11111111 || rd1_data !== 32'h11111111) begin
         failures++;
         $display("FAIL sweep_same_index: rd0=%08h rd1=%08h required 11111111", rd0_data, rd1_data);
      end
      $display("SWEEP r1..r31 read back on both ports");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_r0();
      test_wr_en_low();
      test_same_cycle();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
